// File: rtl/ex_issue_if.sv
// ex_issue_if -- bundle of decode-side, bypass and ALU-side signals of the
// EX issue stage.
//   slave  : view taken by ex_issue (consumes decode/bypass, drives ALU side)
//   master : view taken by the surrounding pipeline (decode, bypass, ALU)
// Parameters: DATA_WIDTH (operand/immediate/bypass width), REG_ADDR_W
// (register index width).
interface ex_issue_if #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 5
);
   // decode -> issue
   logic                  in_valid;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic [DATA_WIDTH-1:0] imm;
   logic                  use_imm;
   logic [3:0]            alu_control_in;
   logic                  reg_write_in;
   // bypass sources
   logic                  fwd_mem_valid;
   logic [REG_ADDR_W-1:0] fwd_mem_rd;
   logic [DATA_WIDTH-1:0] fwd_mem_data;
   logic                  fwd_wb_valid;
   logic [REG_ADDR_W-1:0] fwd_wb_rd;
   logic [DATA_WIDTH-1:0] fwd_wb_data;
   logic                  flush;
   // issue -> ALU
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [3:0]            alu_control;
   logic [REG_ADDR_W-1:0] out_rd;
   logic                  out_reg_write;

   modport slave (
      input  in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm,
             use_imm, alu_control_in, reg_write_in,
             fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
             fwd_wb_valid, fwd_wb_rd, fwd_wb_data, flush, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
             out_reg_write
   );

   modport master (
      output in_valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm,
             use_imm, alu_control_in, reg_write_in,
             fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
             fwd_wb_valid, fwd_wb_rd, fwd_wb_data, flush, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
             out_reg_write
   );
endinterface

// File: rtl/ex_issue.sv
// ex_issue -- single-entry registered issue buffer between decode and the ALU.
// Operands are resolved at capture time through the MEM/WB bypass network
// (MEM has priority, register 0 never bypassed); operand B may be replaced by
// the immediate. Valid/ready handshake on both sides, full throughput.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       ex_issue_if.slave: decode handshake + operands, bypass inputs,
//             flush, ALU-side handshake + issued operands/control
//   perf_issued, perf_stall (only with `define EX_ISSUE_PERF_EN): saturating
//             32-bit counters of captures and of downstream-stall cycles.
module ex_issue #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   ex_issue_if.slave   bus
`ifdef EX_ISSUE_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_stall
`endif
);

   logic                  out_valid_q, out_valid_d;
   logic                  reg_write_q;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]            alu_ctrl_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  in_ready;
   logic                  capture;

   // Flush blocks capture, so a flushed instruction never loads the datapath.
   assign in_ready = (!out_valid_q || bus.out_ready) && !bus.flush;
   assign capture  = bus.in_valid && in_ready;

   // Operand resolution: MEM bypass beats WB bypass; index 0 is hardwired.
   always_comb begin
      alu_a_d = bus.rs1_data;
      if (bus.rs1_addr != '0 && bus.fwd_mem_valid && bus.fwd_mem_rd == bus.rs1_addr)
         alu_a_d = bus.fwd_mem_data;
      else if (bus.rs1_addr != '0 && bus.fwd_wb_valid && bus.fwd_wb_rd == bus.rs1_addr)
         alu_a_d = bus.fwd_wb_data;

      alu_b_d = bus.rs2_data;
      if (bus.use_imm)
         alu_b_d = bus.imm;
      else if (bus.rs2_addr != '0 && bus.fwd_mem_valid && bus.fwd_mem_rd == bus.rs2_addr)
         alu_b_d = bus.fwd_mem_data;
      else if (bus.rs2_addr != '0 && bus.fwd_wb_valid && bus.fwd_wb_rd == bus.rs2_addr)
         alu_b_d = bus.fwd_wb_data;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (bus.flush)
         out_valid_d = 1'b0;
      else if (capture)
         out_valid_d = 1'b1;
      else if (bus.out_ready)
         out_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         reg_write_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= '0;
         rd_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (capture) begin
            reg_write_q <= bus.reg_write_in;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= bus.alu_control_in;
            rd_q        <= bus.rd_addr;
         end
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.alu_a         = alu_a_q;
   assign bus.alu_b         = alu_b_q;
   assign bus.alu_control   = alu_ctrl_q;
   assign bus.out_rd        = rd_q;
   // Gated so a stale write-enable left by flush never leaks out.
   assign bus.out_reg_write = out_valid_q && reg_write_q;

`ifdef EX_ISSUE_PERF_EN
   logic [31:0] issued_q, issued_d;
   logic [31:0] stall_q, stall_d;

   always_comb begin
      issued_d = issued_q;
      if (capture && issued_q != '1)
         issued_d = issued_q + 32'd1;
      stall_d = stall_q;
      if (out_valid_q && !bus.out_ready && stall_q != '1)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         issued_q <= issued_d;
         stall_q  <= stall_d;
      end
   end

   assign perf_issued = issued_q;
   assign perf_stall  = stall_q;
`endif

endmodule
